// File: rtl/fetch_align_buf.sv
// Instruction fetch and alignment buffer feeding the decoder.
// Issues word-aligned reads, buffers up to three halfwords and presents one
// 16- or 32-bit instruction per cycle, including word-straddling ones.
// Build option: define FETCH_C_ALIGN_EN for halfword alignment and compressed
// support; when undefined the buffer works on whole words only.
module fetch_align_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_compressed
);

`ifdef FETCH_C_ALIGN_EN
    localparam bit CAlign = 1'b1;
`else
    localparam bit CAlign = 1'b0;
`endif

    // Word mode drops PC bit 1 so the buffer always holds whole words.
    localparam logic [31:0] PcMask    = CAlign ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    localparam logic [31:0] ResetPc   = RESET_PC & PcMask;
    localparam logic [31:0] ResetAddr = {RESET_PC[31:2], 2'b00};
    localparam bit          ResetSkip = CAlign & RESET_PC[1];

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_buf [0:2];
    logic [15:0] w_buf_d [0:2];
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_d;
    logic [1:0]  w_base;
    logic [1:0]  w_pop;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic        r_skip;
    logic        w_head_c;
    logic        w_valid;
    logic        w_consume;
    logic        w_append;
    logic        w_room;
    logic        w_accept;

    // Head decode and per-cycle events.
    always_comb begin
        w_head_c  = CAlign && (r_buf[0][1:0] != 2'b11);
        w_valid   = w_head_c ? (r_cnt >= 2'd1) : (r_cnt >= 2'd2);
        w_consume = w_valid && !i_stall && !i_redirect;
        w_pop     = !w_consume ? 2'd0 : (w_head_c ? 2'd1 : 2'd2);
        w_append  = (r_state == StWait) && i_imem_valid && !i_redirect;
        w_room    = CAlign ? (r_cnt <= 2'd1) : (r_cnt == 2'd0);
        w_accept  = o_imem_req && i_imem_ready;
    end

    // Next buffer contents: shift out consumed halfwords, then append behind survivors.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_buf_d[i] = r_buf[i];
        end
        case (w_pop)
            2'd1: begin
                w_buf_d[0] = r_buf[1];
                w_buf_d[1] = r_buf[2];
                w_buf_d[2] = 16'h0000;
            end
            2'd2: begin
                w_buf_d[0] = r_buf[2];
                w_buf_d[1] = 16'h0000;
                w_buf_d[2] = 16'h0000;
            end
            default: ;
        endcase
        w_base = r_cnt - w_pop;
        // A request is only issued with count<=1, so base+1 never exceeds slot 2.
        if (w_append) begin
            for (int i = 0; i < 3; i++) begin
                if (r_skip) begin
                    if (i == int'(w_base)) w_buf_d[i] = i_imem_data[31:16];
                end else begin
                    if (i == int'(w_base)) w_buf_d[i] = i_imem_data[15:0];
                    else if (i == int'(w_base) + 1) w_buf_d[i] = i_imem_data[31:16];
                end
            end
        end
        w_cnt_d = w_base + (!w_append ? 2'd0 : (r_skip ? 2'd1 : 2'd2));
    end

    // Buffer, PC and fetch pointer state; redirect overrides everything else.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= 16'h0000;
            end
            r_cnt  <= 2'd0;
            r_pc   <= ResetPc;
            r_addr <= ResetAddr;
            r_skip <= ResetSkip;
        end else if (i_redirect) begin
            r_cnt  <= 2'd0;
            r_pc   <= i_redirect_pc & PcMask;
            r_addr <= {i_redirect_pc[31:2], 2'b00};
            r_skip <= CAlign & i_redirect_pc[1];
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= w_buf_d[i];
            end
            r_cnt <= w_cnt_d;
            if (w_consume) begin
                r_pc <= r_pc + (w_head_c ? 32'd2 : 32'd4);
            end
            if (w_append) begin
                r_addr <= r_addr + 32'd4;
                r_skip <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state: one request in flight, stale responses dropped after a redirect.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_d = StWait;
            end
            StWait: begin
                if (i_redirect) w_state_d = i_imem_valid ? StIdle : StDrop;
                else if (i_imem_valid) w_state_d = StIdle;
            end
            StDrop: begin
                if (i_imem_valid) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM outputs and instruction presentation.
    always_comb begin
        o_imem_req   = (r_state == StIdle) && w_room && !i_redirect && i_rst_n;
        o_imem_addr  = r_addr;
        o_valid      = w_valid;
        o_compressed = w_valid && w_head_c;
        o_pc         = r_pc;
        if (!w_valid) o_instr = 32'h0000_0000;
        else if (w_head_c) o_instr = {16'h0000, r_buf[0]};
        else o_instr = {r_buf[1], r_buf[0]};
    end

endmodule
